id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 flush  input  1  branch/jump kill; ID instruction SHALL be replaced by a bubble.
REQ-004 id_rs_data  input  32  register-file rs read value.
REQ-005 id_rt_data  input  32  register-file rt read value.
REQ-006 id_imm  input  32  extended immediate.
REQ-007 id_rs  input  5  rs index.
REQ-008 id_rt  input  5  rt index.
REQ-009 id_dst  input  5  destination index, already resolved by decode.
REQ-010 id_shamt  input  6  shift amount.
REQ-011 id_alu_ctrl  input  4  ALU opcode.
REQ-012 id_alu_src  input  1  1 selects id_imm as operand 2.
REQ-013 id_ctrl  input  4  {reg_write, mem_read, mem_write, mem_to_reg}.
REQ-014 mem_reg_write  input  1  MEM-stage instruction writes a register.
REQ-015 mem_rd  input  5  MEM-stage destination.
REQ-016 mem_alu_res  input  32  MEM-stage ALU result.
REQ-017 wb_reg_write  input  1  WB-stage instruction writes a register.
REQ-018 wb_rd  input  5  WB-stage destination.
REQ-019 wb_data  input  32  WB-stage write data.
REQ-020 ex_data1  output  32  ALU operand 1.
REQ-021 ex_data2  output  32  ALU operand 2.
REQ-022 ex_shamt  output  6  registered shift amount.
REQ-023 ex_alu_ctrl  output  4  registered ALU opcode.
REQ-024 ex_store_data  output  32  forwarded rt value for stores.
REQ-025 ex_dst  output  5  registered destination.
REQ-026 ex_ctrl  output  4  registered id_ctrl.
REQ-027 stall  output  1  combinational; freezes PC and IF/ID.

Function
REQ-028 Each edge SHALL capture all id_* fields unless flush or stall, in which case a bubble (every field zero) SHALL be captured.
REQ-029 flush SHALL have priority over stall; stall SHALL be 0 while flush=1.
REQ-030 stall SHALL be 1 when ex_ctrl mem_read=1, ex_dst!=0, and ex_dst equals id_rs or id_rt (rt compared unconditionally).
REQ-031 Forwarded rs/rt SHALL select mem_alu_res if mem_reg_write=1, mem_rd!=0, and mem_rd matches; else wb_data if the same conditions hold for wb; else the registered value; MEM SHALL win over WB.
REQ-032 Index 0 SHALL never be forwarded.
REQ-033 ex_data1 SHALL be forwarded rs; ex_data2 SHALL be registered imm if registered alu_src=1, else forwarded rt; ex_store_data SHALL always be forwarded rt.
REQ-034 Operand outputs SHALL be combinational from stage registers and forwarding inputs (zero added latency); all other outputs SHALL be direct register outputs (one-cycle latency).
REQ-035 A stalled instruction SHALL remain on id_* and SHALL be captured on the first edge with stall=0.

Reset
REQ-036 rst=1 SHALL asynchronously clear every stage register, including mid-stall, giving ex_data1=0, ex_data2=0, ex_store_data=0, ex_shamt=0, ex_alu_ctrl=0, ex_dst=0, ex_ctrl=0, stall=0.
REQ-037 The first capture after rst deasserts SHALL follow REQ-028 normally.

Configuration
REQ-038 With FORWARD_EN defined, REQ-030/031 SHALL apply.
REQ-039 Without FORWARD_EN, forwarding SHALL be removed, and stall SHALL be 1 on any rs/rt match against ex_dst (when ex_ctrl reg_write=1) or mem_rd (when mem_reg_write=1), index 0 excluded; WB hazards SHALL be left to the register file.

Verification
REQ-040 EX instruction writes r3; next instruction in EX has rs=3; mem_reg_write=1, mem_rd=3, mem_alu_res=0x0000_00AA -> ex_data1=0x0000_00AA.
REQ-041 mem_rd=wb_rd=5, mem_alu_res=0x11, wb_data=0x22, rt=5, alu_src=0 -> ex_data2=0x11; with alu_src=1 and imm=0x7 -> ex_data2=0x7 and ex_store_data=0x11.
REQ-042 Load with ex_dst=4, id_rs=4 -> stall=1 for exactly one cycle, then bubble in EX (ex_ctrl=0), then dependent instruction captured.
REQ-043 stall and flush asserted together -> stall=0 and bubble captured.
REQ-044 rst pulsed mid-operation for half a cycle -> all outputs 0 immediately, without waiting for clk.
REQ-045 mem_rd=0, mem_reg_write=1, mem_alu_res=0xFFFF_FFFF, rs=0 -> ex_data1=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for a 5-stage in-order pipeline. Captures the
//   decoded instruction each cycle, inserts a bubble on flush or a load-use
//   stall, and produces the EX-stage ALU operands with MEM/WB forwarding
//   applied combinationally on the registered values.
//
//   Build option: define FORWARD_EN to enable MEM/WB forwarding with
//   load-use-only stalls. Without it, operands come straight from the stage
//   registers and any RAW hazard against EX or MEM stalls.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               kill the ID instruction (bubble captured)
//   id_*                decoded instruction fields from ID
//   mem_reg_write/rd/alu_res   MEM-stage writeback info (forward source)
//   wb_reg_write/rd/data       WB-stage writeback info (forward source)
//   ex_data1/ex_data2   ALU operands (combinational, forwarded)
//   ex_store_data       forwarded rt value for stores
//   ex_shamt/alu_ctrl/dst/ctrl registered instruction fields
//   stall               combinational hazard stall to PC and IF/ID
// ----------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dst,
    input  logic [5:0]  id_shamt,
    input  logic [3:0]  id_alu_ctrl,
    input  logic        id_alu_src,
    input  logic [3:0]  id_ctrl,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_alu_res,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] ex_data1,
    output logic [31:0] ex_data2,
    output logic [5:0]  ex_shamt,
    output logic [3:0]  ex_alu_ctrl,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dst,
    output logic [3:0]  ex_ctrl,
    output logic        stall
);

    // id_ctrl / ex_ctrl bit positions: {reg_write, mem_read, mem_write, mem_to_reg}
    localparam int CTRL_REG_WRITE = 3;
    localparam int CTRL_MEM_READ  = 2;

    logic [31:0] rs_data_q, rs_data_d;
    logic [31:0] rt_data_q, rt_data_d;
    logic [31:0] imm_q,     imm_d;
    logic [4:0]  rs_q,      rs_d;
    logic [4:0]  rt_q,      rt_d;
    logic [4:0]  dst_q,     dst_d;
    logic [5:0]  shamt_q,   shamt_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic        alu_src_q, alu_src_d;
    logic [3:0]  ctrl_q,    ctrl_d;

    logic        bubble;
    logic [31:0] fwd_rs, fwd_rt;

    // Hazard detection. rt is compared even for I-type instructions, which
    // may cost a spurious stall but never misses a real dependency.
    always_comb begin
        stall = 1'b0;
`ifdef FORWARD_EN
        // Only a load in EX cannot be forwarded in time.
        if (ctrl_q[CTRL_MEM_READ] && dst_q != 5'd0 &&
            (dst_q == id_rs || dst_q == id_rt))
            stall = 1'b1;
`else
        if (ctrl_q[CTRL_REG_WRITE] && dst_q != 5'd0 &&
            (dst_q == id_rs || dst_q == id_rt))
            stall = 1'b1;
        if (mem_reg_write && mem_rd != 5'd0 &&
            (mem_rd == id_rs || mem_rd == id_rt))
            stall = 1'b1;
`endif
        // A flushed instruction is dead, so it must not hold the front end.
        if (flush)
            stall = 1'b0;
    end

    assign bubble = flush | stall;

    always_comb begin
        rs_data_d  = id_rs_data;
        rt_data_d  = id_rt_data;
        imm_d      = id_imm;
        rs_d       = id_rs;
        rt_d       = id_rt;
        dst_d      = id_dst;
        shamt_d    = id_shamt;
        alu_ctrl_d = id_alu_ctrl;
        alu_src_d  = id_alu_src;
        ctrl_d     = id_ctrl;
        if (bubble) begin
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            dst_d      = '0;
            shamt_d    = '0;
            alu_ctrl_d = '0;
            alu_src_d  = 1'b0;
            ctrl_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            dst_q      <= '0;
            shamt_q    <= '0;
            alu_ctrl_q <= '0;
            alu_src_q  <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            dst_q      <= dst_d;
            shamt_q    <= shamt_d;
            alu_ctrl_q <= alu_ctrl_d;
            alu_src_q  <= alu_src_d;
            ctrl_q     <= ctrl_d;
        end
    end

`ifdef FORWARD_EN
    // MEM is younger than WB, so it wins; r0 is hardwired and never forwarded.
    always_comb begin
        fwd_rs = rs_data_q;
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs_q)
            fwd_rs = mem_alu_res;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs_q)
            fwd_rs = wb_data;

        fwd_rt = rt_data_q;
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rt_q)
            fwd_rt = mem_alu_res;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rt_q)
            fwd_rt = wb_data;
    end
`else
    // WB hazards are resolved by the register file (write-before-read),
    // MEM/EX hazards by stalling, so the registered values are final.
    assign fwd_rs = rs_data_q;
    assign fwd_rt = rt_data_q;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mem_alu_res, wb_reg_write, wb_rd, wb_data, rs_q, rt_q};
`endif

    assign ex_data1      = fwd_rs;
    assign ex_data2      = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_shamt      = shamt_q;
    assign ex_alu_ctrl   = alu_ctrl_q;
    assign ex_dst        = dst_q;
    assign ex_ctrl       = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. A table of instruction vectors is
//   applied one per cycle; expected EX outputs are queued when the vector is
//   driven and popped when the instruction reaches EX. Hand-written sequences
//   cover load-use stall, flush-over-stall and asynchronous reset.
//   Expectations track the FORWARD_EN build option.
// ----------------------------------------------------------------------------
`ifdef FORWARD_EN
`define FW(a, b) (a)
`else
`define FW(a, b) (b)
`endif

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_dst = '0;
    logic [5:0]  id_shamt = '0;
    logic [3:0]  id_alu_ctrl = '0;
    logic        id_alu_src = 1'b0;
    logic [3:0]  id_ctrl = '0;
    logic        mem_reg_write = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_alu_res = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] ex_data1, ex_data2, ex_store_data;
    logic [5:0]  ex_shamt;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_dst;
    logic [3:0]  ex_ctrl;
    logic        stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_shamt(id_shamt),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_ctrl(id_ctrl),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_res(mem_alu_res),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_shamt(ex_shamt),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_ctrl(ex_ctrl), .stall(stall)
    );

    typedef struct {
        logic        flush;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dst;
        logic [5:0]  shamt;
        logic [3:0]  aluc;
        logic        src;
        logic [3:0]  ctrl;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] e_d1, e_d2, e_st;
        logic [5:0]  e_shamt;
        logic [3:0]  e_aluc;
        logic [4:0]  e_dst;
        logic [3:0]  e_ctrl;
    } vec_t;

    typedef struct {
        logic [31:0] d1, d2, st;
        logic [5:0]  shamt;
        logic [3:0]  aluc;
        logic [4:0]  dst;
        logic [3:0]  ctrl;
    } exp_t;

    localparam int NV = 8;
    vec_t vec[NV];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_id(input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                            input logic [5:0] sh, input logic [3:0] aluc, input logic src,
                            input logic [3:0] ctrl);
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_rs = rs; id_rt = rt; id_dst = dst; id_shamt = sh;
        id_alu_ctrl = aluc; id_alu_src = src; id_ctrl = ctrl;
    endtask

    task automatic clear_fwd();
        mem_reg_write = 1'b0; mem_rd = '0; mem_alu_res = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".data1"}, ex_data1, 32'h0);
        chk({tag, ".data2"}, ex_data2, 32'h0);
        chk({tag, ".store"}, ex_store_data, 32'h0);
        chk({tag, ".shamt"}, {26'h0, ex_shamt}, 32'h0);
        chk({tag, ".aluc"},  {28'h0, ex_alu_ctrl}, 32'h0);
        chk({tag, ".dst"},   {27'h0, ex_dst}, 32'h0);
        chk({tag, ".ctrl"},  {28'h0, ex_ctrl}, 32'h0);
        chk({tag, ".stall"}, {31'h0, stall}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        //           fl rs_data       rt_data       imm            rs    rt    dst    shamt aluc  src  ctrl     mrw  mrd   mres           wrw  wrd   wdat           e_d1                        e_d2                         e_st                         e_sh  e_al  e_dst  e_ctrl
        vec[0] = '{1'b0, 32'h100, 32'h200, 32'h55,       5'd3, 5'd7, 5'd8,  6'd2, 4'd2, 1'b0, 4'b1000, 1'b1, 5'd3, 32'hAA,       1'b0, 5'd0, 32'h0,     `FW(32'hAA, 32'h100),      32'h200,                     32'h200,                     6'd2, 4'd2, 5'd8,  4'b1000};
        vec[1] = '{1'b0, 32'h10,  32'h50,  32'h7,        5'd1, 5'd5, 5'd9,  6'd0, 4'd1, 1'b0, 4'b1000, 1'b1, 5'd5, 32'h11,       1'b1, 5'd5, 32'h22,    32'h10,                    `FW(32'h11, 32'h50),         `FW(32'h11, 32'h50),         6'd0, 4'd1, 5'd9,  4'b1000};
        vec[2] = '{1'b0, 32'h10,  32'h50,  32'h7,        5'd1, 5'd5, 5'd10, 6'd0, 4'd1, 1'b1, 4'b1000, 1'b1, 5'd5, 32'h11,       1'b1, 5'd5, 32'h22,    32'h10,                    32'h7,                       `FW(32'h11, 32'h50),         6'd0, 4'd1, 5'd10, 4'b1000};
        vec[3] = '{1'b0, 32'h60,  32'h20,  32'h0,        5'd6, 5'd2, 5'd11, 6'd4, 4'd5, 1'b0, 4'b1001, 1'b1, 5'd2, 32'h77,       1'b1, 5'd6, 32'h66,    `FW(32'h66, 32'h60),       `FW(32'h77, 32'h20),         `FW(32'h77, 32'h20),         6'd4, 4'd5, 5'd11, 4'b1001};
        vec[4] = '{1'b0, 32'h0,   32'h44,  32'h0,        5'd0, 5'd4, 5'd20, 6'd0, 4'd0, 1'b0, 4'b1000, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h123,   32'h0,                     32'h44,                      32'h44,                      6'd0, 4'd0, 5'd20, 4'b1000};
        vec[5] = '{1'b0, 32'hC,   32'hD,   32'h0,        5'd12,5'd13,5'd0,  6'd1, 4'd7, 1'b0, 4'b0110, 1'b0, 5'd12,32'hBAD,      1'b0, 5'd13,32'hBEE,   32'hC,                     32'hD,                       32'hD,                       6'd1, 4'd7, 5'd0,  4'b0110};
        vec[6] = '{1'b1, 32'h33,  32'h34,  32'h35,       5'd3, 5'd4, 5'd5,  6'd9, 4'd9, 1'b1, 4'b1111, 1'b1, 5'd0, 32'h99,       1'b0, 5'd0, 32'h0,     32'h0,                     32'h0,                       32'h0,                       6'd0, 4'd0, 5'd0,  4'b0000};
        vec[7] = '{1'b0, 32'hE0,  32'hF0,  32'hFFFF_FFF0,5'd14,5'd15,5'd31, 6'd63,4'd15,1'b1, 4'b1111, 1'b1, 5'd15,32'h5,        1'b0, 5'd0, 32'h0,     32'hE0,                    32'hFFFF_FFF0,               `FW(32'h5, 32'hF0),          6'd63,4'd15,5'd31, 4'b1111};

        // Reset state
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            flush = vec[i].flush;
            drive_id(vec[i].rs_data, vec[i].rt_data, vec[i].imm, vec[i].rs, vec[i].rt,
                     vec[i].dst, vec[i].shamt, vec[i].aluc, vec[i].src, vec[i].ctrl);
            clear_fwd();
            e.d1 = vec[i].e_d1; e.d2 = vec[i].e_d2; e.st = vec[i].e_st;
            e.shamt = vec[i].e_shamt; e.aluc = vec[i].e_aluc;
            e.dst = vec[i].e_dst; e.ctrl = vec[i].e_ctrl;
            sb.push_back(e);
            #1 chk($sformatf("v%0d.stall", i), {31'h0, stall}, 32'h0);
            @(posedge clk);
            #1;
            mem_reg_write = vec[i].mrw; mem_rd = vec[i].mrd; mem_alu_res = vec[i].mres;
            wb_reg_write = vec[i].wrw; wb_rd = vec[i].wrd; wb_data = vec[i].wdat;
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL v%0d.scoreboard: got empty queue expected an entry", i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d.data1", i), ex_data1, e.d1);
                chk($sformatf("v%0d.data2", i), ex_data2, e.d2);
                chk($sformatf("v%0d.store", i), ex_store_data, e.st);
                chk($sformatf("v%0d.shamt", i), {26'h0, ex_shamt}, {26'h0, e.shamt});
                chk($sformatf("v%0d.aluc", i),  {28'h0, ex_alu_ctrl}, {28'h0, e.aluc});
                chk($sformatf("v%0d.dst", i),   {27'h0, ex_dst}, {27'h0, e.dst});
                chk($sformatf("v%0d.ctrl", i),  {28'h0, ex_ctrl}, {28'h0, e.ctrl});
            end
        end

        // Load-use: load r4 in EX, dependent rs=4 in ID
        @(negedge clk);
        flush = 1'b0;
        clear_fwd();
        drive_id(32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd4, 6'd0, 4'd0, 1'b0, 4'b1101);
        #1 chk("lu.load_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        drive_id(32'h400, 32'h900, 32'h0, 5'd4, 5'd9, 5'd5, 6'd0, 4'd3, 1'b0, 4'b1000);
        #1 chk("lu.stall_on", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1;
        chk("lu.bubble_ctrl", {28'h0, ex_ctrl}, 32'h0);
        chk("lu.bubble_dst",  {27'h0, ex_dst}, 32'h0);
        @(negedge clk);
        #1 chk("lu.stall_off", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("lu.dep_dst",   {27'h0, ex_dst}, 32'd5);
        chk("lu.dep_ctrl",  {28'h0, ex_ctrl}, 32'b1000);
        chk("lu.dep_data1", ex_data1, 32'h400);

        // Flush has priority over a pending load-use stall
        @(negedge clk);
        drive_id(32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd6, 6'd0, 4'd0, 1'b0, 4'b1101);
        @(negedge clk);
        drive_id(32'h600, 32'h0, 32'h0, 5'd6, 5'd0, 5'd7, 6'd3, 4'd3, 1'b0, 4'b1000);
        #1 chk("fs.stall_pre", {31'h0, stall}, 32'h1);
        flush = 1'b1;
        #1 chk("fs.stall_flush", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("fs.bubble_ctrl",  {28'h0, ex_ctrl}, 32'h0);
        chk("fs.bubble_dst",   {27'h0, ex_dst}, 32'h0);
        chk("fs.bubble_shamt", {26'h0, ex_shamt}, 32'h0);

        // Asynchronous reset during a stall
        @(negedge clk);
        flush = 1'b0;
        drive_id(32'h77, 32'h88, 32'h0, 5'd1, 5'd2, 5'd7, 6'd5, 4'd3, 1'b0, 4'b1100);
        @(posedge clk);
        #1;
        chk("rs.pre_dst",   {27'h0, ex_dst}, 32'd7);
        chk("rs.pre_data1", ex_data1, 32'h77);
        @(negedge clk);
        drive_id(32'h99, 32'h33, 32'h0, 5'd7, 5'd3, 5'd8, 6'd2, 4'd4, 1'b0, 4'b1000);
        #1 chk("rs.stall_on", {31'h0, stall}, 32'h1);
        #1 rst = 1'b1;
        #1 chk_all_zero("rs.async");
        #4 rst = 1'b0;
        #1 chk("rs.stall_after", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("rs.first_dst",   {27'h0, ex_dst}, 32'd8);
        chk("rs.first_ctrl",  {28'h0, ex_ctrl}, 32'b1000);
        chk("rs.first_shamt", {26'h0, ex_shamt}, 32'd2);
        chk("rs.first_data1", ex_data1, 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
